// File: rtl/count_event_sampler_if.sv
// Output stream of the count event sampler: head entry of the event FIFO with valid/ready.
interface count_event_sampler_if #(
  parameter int CW  = 4,
  parameter int TSW = 16
);
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  out_count;
  logic [TSW-1:0] out_ts;
  logic           out_wrap;

  modport master (output out_valid, out_count, out_ts, out_wrap, input out_ready);
  modport slave  (input out_valid, out_count, out_ts, out_wrap, output out_ready);
endinterface

// File: rtl/count_event_sampler.sv
// Records changes of an upstream count as {count, timestamp, wrap} events in a small FIFO.
// Optional SAMPLER_WRAP_CNT_EN adds a saturating wrap_cnt output counting detected wraps.
module count_event_sampler #(
  parameter int CW    = 4,
  parameter int DEPTH = 8,
  parameter int TSW   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CW-1:0]            count,
  input  logic                     sample_en,
  count_event_sampler_if.master    out,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     overflow,
  input  logic                     clr_ovf
`ifdef SAMPLER_WRAP_CNT_EN
  , output logic [7:0]             wrap_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CW + TSW + 1;

  logic [EW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr, nh_ptr;
  logic [AW:0]    fill_next;
  logic [TSW-1:0] ts;
  logic [CW-1:0]  prev_count;
  logic           first;
  logic           ev, wrap_det, empty, full, pop, push, drop;
  logic [EW-1:0]  push_data;

  always_comb begin
    ev        = sample_en && (first || (count != prev_count));
    wrap_det  = ev && !first && (count < prev_count);
    empty     = (fill == '0);
    full      = (fill == (AW+1)'(DEPTH));
    pop       = !empty && out.out_ready;
    push      = ev && (!full || pop);
    drop      = ev && full && !pop;
    push_data = {wrap_det, ts, count};
    nh_ptr    = rd_ptr + AW'(pop);
    fill_next = fill + (AW+1)'(push) - (AW+1)'(pop);
  end

  assign out.out_valid = !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts            <= '0;
      prev_count    <= '0;
      first         <= 1'b1;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill          <= '0;
      overflow      <= 1'b0;
      out.out_count <= '0;
      out.out_ts    <= '0;
      out.out_wrap  <= 1'b0;
    end else begin
      ts <= ts + TSW'(1);
      if (sample_en) begin
        prev_count <= count;
        first      <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fill <= fill_next;
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      // Head outputs are registered so they hold once the FIFO drains; when the
      // new head is the entry being written this cycle, take it from push_data.
      if ((fill_next != '0) && (empty || pop)) begin
        if (push && (nh_ptr == wr_ptr))
          {out.out_wrap, out.out_ts, out.out_count} <= push_data;
        else
          {out.out_wrap, out.out_ts, out.out_count} <= mem[nh_ptr];
      end
    end
  end

`ifdef SAMPLER_WRAP_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              wrap_cnt <= '0;
    else if (clr_ovf)                      wrap_cnt <= '0;
    else if (wrap_det && wrap_cnt != '1)   wrap_cnt <= wrap_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_count_event_sampler.sv
// Self-checking bench for count_event_sampler: directed table, corner sequences, random vs queue model.
module tb_count_event_sampler;
  localparam int CW = 4, DEPTH = 8, TSW = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [CW-1:0] count;
  logic         sample_en, clr_ovf;
  logic [3:0]   fill;
  logic         overflow;
`ifdef SAMPLER_WRAP_CNT_EN
  logic [7:0]   wrap_cnt;
`endif

  count_event_sampler_if #(.CW(CW), .TSW(TSW)) bus ();

  count_event_sampler #(.CW(CW), .DEPTH(DEPTH), .TSW(TSW)) dut (
    .clk(clk), .rst(rst), .count(count), .sample_en(sample_en), .out(bus),
    .fill(fill), .overflow(overflow), .clr_ovf(clr_ovf)
`ifdef SAMPLER_WRAP_CNT_EN
    , .wrap_cnt(wrap_cnt)
`endif
  );

  always #5 clk = ~clk;

  int unsigned vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] c, input bit en, input bit rdy, input bit clr);
    count = c; sample_en = en; bus.out_ready = rdy; clr_ovf = clr;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; count = '0; sample_en = 1'b0; bus.out_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Behavioural model: event queue plus sticky flags
  typedef struct { logic [3:0] c; int unsigned ts; bit w; } ent_t;
  ent_t        q[$];
  ent_t        m_head;
  int unsigned m_ts, m_prev, m_wc;
  bit          m_first, m_ovf;

  function automatic void model_reset();
    q.delete();
    m_ts = 0; m_prev = 0; m_first = 1; m_ovf = 0; m_wc = 0;
    m_head = '{4'd0, 0, 1'b0};
  endfunction

  function automatic void model_step(input logic [3:0] c, input bit en, input bit rdy, input bit clr);
    bit e, w, popd, was_full;
    e        = en && (m_first || c != m_prev);
    w        = e && !m_first && (c < m_prev);
    popd     = (q.size() != 0) && rdy;
    was_full = (q.size() == DEPTH);
    if (popd) void'(q.pop_front());
    if (e && (!was_full || popd)) q.push_back('{c, m_ts, w});
    if (e && was_full && !popd) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (clr) m_wc = 0;
    else if (w && m_wc < 255) m_wc++;
    if (en) begin m_prev = c; m_first = 0; end
    m_ts = (m_ts + 1) % (1 << TSW);
    if (q.size() != 0) m_head = q[0];
  endfunction

  task automatic compare_model();
    chk("rnd_valid", bus.out_valid, q.size() != 0);
    chk("rnd_fill", fill, q.size());
    chk("rnd_ovf", overflow, m_ovf);
    chk("rnd_count", bus.out_count, m_head.c);
    chk("rnd_ts", bus.out_ts, m_head.ts);
    chk("rnd_wrap", bus.out_wrap, m_head.w);
`ifdef SAMPLER_WRAP_CNT_EN
    chk("rnd_wrap_cnt", wrap_cnt, m_wc);
`endif
  endtask

  typedef struct {
    logic [3:0] c; bit en; bit rdy;
    bit v; logic [3:0] ec; int unsigned ets; bit ew; int unsigned ef; bit eo;
  } vec_t;
  vec_t tbl[21];

  initial begin
    logic [3:0] c;
    bit en, rdy, clr;
    int unsigned p;

    tbl[0]  = '{4'd0,  1, 1, 1, 4'd0,  0,  0, 1, 0};
    tbl[1]  = '{4'd1,  1, 1, 1, 4'd1,  1,  0, 1, 0};
    tbl[2]  = '{4'd2,  1, 1, 1, 4'd2,  2,  0, 1, 0};
    tbl[3]  = '{4'd3,  1, 1, 1, 4'd3,  3,  0, 1, 0};
    tbl[4]  = '{4'd3,  1, 1, 0, 4'd3,  3,  0, 0, 0};
    tbl[5]  = '{4'd13, 1, 1, 1, 4'd13, 5,  0, 1, 0};
    tbl[6]  = '{4'd14, 1, 1, 1, 4'd14, 6,  0, 1, 0};
    tbl[7]  = '{4'd15, 1, 1, 1, 4'd15, 7,  0, 1, 0};
    tbl[8]  = '{4'd0,  1, 1, 1, 4'd0,  8,  1, 1, 0};
    tbl[9]  = '{4'd1,  1, 1, 1, 4'd1,  9,  0, 1, 0};
    tbl[10] = '{4'd1,  1, 1, 0, 4'd1,  9,  0, 0, 0};
    tbl[11] = '{4'd5,  1, 1, 1, 4'd5,  11, 0, 1, 0};
    tbl[12] = '{4'd5,  1, 0, 1, 4'd5,  11, 0, 1, 0};
    tbl[13] = '{4'd5,  1, 0, 1, 4'd5,  11, 0, 1, 0};
    tbl[14] = '{4'd5,  1, 1, 0, 4'd5,  11, 0, 0, 0};
    tbl[15] = '{4'd9,  0, 1, 0, 4'd5,  11, 0, 0, 0};
    tbl[16] = '{4'd9,  1, 1, 1, 4'd9,  16, 0, 1, 0};
    tbl[17] = '{4'd2,  0, 1, 0, 4'd9,  16, 0, 0, 0};
    tbl[18] = '{4'd2,  1, 1, 1, 4'd2,  18, 1, 1, 0};
    tbl[19] = '{4'd2,  1, 1, 0, 4'd2,  18, 1, 0, 0};
    tbl[20] = '{4'd3,  1, 0, 1, 4'd3,  20, 0, 1, 0};

    // Reset state
    rst = 1'b0; count = '0; sample_en = 1'b0; bus.out_ready = 1'b0; clr_ovf = 1'b0;
    #3;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", bus.out_count, 0);
    chk("rst_ts", bus.out_ts, 0);
    chk("rst_wrap", bus.out_wrap, 0);

    // Directed table
    do_reset();
    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].c, tbl[i].en, tbl[i].rdy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].v);
      chk($sformatf("tbl%0d_count", i), bus.out_count, tbl[i].ec);
      chk($sformatf("tbl%0d_ts", i), bus.out_ts, tbl[i].ets);
      chk($sformatf("tbl%0d_wrap", i), bus.out_wrap, tbl[i].ew);
      chk($sformatf("tbl%0d_fill", i), fill, tbl[i].ef);
      chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].eo);
    end
`ifdef SAMPLER_WRAP_CNT_EN
    chk("tbl_wrap_cnt", wrap_cnt, 2);
`endif

    // Overflow: fill with ready low, drain in order, sticky until cleared
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(4'(i), 1, 0, 0);
      if (i == 7) begin
        chk("ovf_fill8", fill, 8);
        chk("ovf_not_yet", overflow, 0);
      end
    end
    chk("ovf_fill_full", fill, 8);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", bus.out_count, 0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d_valid", i), bus.out_valid, 1);
      chk($sformatf("drain%0d_count", i), bus.out_count, i);
      drive(4'd9, 1, 1, 0);
    end
    chk("drain_empty", fill, 0);
    chk("drain_valid0", bus.out_valid, 0);
    chk("drain_ovf_sticky", overflow, 1);
    drive(4'd9, 1, 1, 0);
    chk("empty_ready_fill", fill, 0);
    chk("empty_ready_ovf", overflow, 1);
    drive(4'd9, 1, 1, 1);
    chk("clr_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) drive(4'((10 + i) % 16), 1, 0, 0);
    chk("refill", fill, 8);
    drive(4'd2, 1, 0, 1);
    chk("set_wins", overflow, 1);
    chk("set_wins_fill", fill, 8);

    // Full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) drive(4'(i), 1, 0, 0);
    chk("full_fill", fill, 8);
    drive(4'd8, 1, 1, 0);
    chk("pushpop_fill", fill, 8);
    chk("pushpop_ovf", overflow, 0);
    chk("pushpop_head", bus.out_count, 1);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 10; i < 15; i++) drive(4'(i), 1, 0, 0);
    chk("mid_fill5", fill, 5);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", bus.out_valid, 0);
    chk("async_fill", fill, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(4'd7, 1, 0, 0);
    chk("post_rst_valid", bus.out_valid, 1);
    chk("post_rst_count", bus.out_count, 7);
    chk("post_rst_wrap", bus.out_wrap, 0);
    chk("post_rst_ts", bus.out_ts, 0);

    // Randomized against the model
    do_reset();
    model_reset();
    c = '0;
    p = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) p = $urandom_range(5, 95);
      if ($urandom_range(0, 1) == 0) c = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 99) < p);
      clr = ($urandom_range(0, 39) == 0);
      model_step(c, en, rdy, clr);
      drive(c, en, rdy, clr);
      compare_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
